// File: rtl/data_transmitter.sv
// rtl/data_transmitter.sv - serialises a 32-bit word into four MSB-first byte strobes
// with link back-pressure and a programmable inter-byte gap.
module data_transmitter #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_data_ready,
  input  logic        in_tx_busy,
  output logic [7:0]  out_data,
  output logic        out_data_ready,
  output logic        out_busy,
  output logic        out_dropped
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state;
  logic [31:0]     shreg;
  logic [2:0]      byte_idx;
  logic [CW-1:0]   gap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shreg          <= '0;
      byte_idx       <= '0;
      gap_cnt        <= '0;
      out_data       <= '0;
      out_data_ready <= 1'b0;
      out_busy       <= 1'b0;
      out_dropped    <= 1'b0;
    end else begin
      out_data_ready <= 1'b0;
      // Any request while a word is in flight is refused; the current word is untouched.
      out_dropped    <= in_data_ready && (state != IDLE);
      case (state)
        IDLE: begin
          if (in_data_ready) begin
            shreg    <= in_data;
            byte_idx <= '0;
            out_busy <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (!in_tx_busy) begin
            out_data       <= shreg[31:24];
            shreg          <= {shreg[23:0], 8'h00};
            out_data_ready <= 1'b1;
            byte_idx       <= byte_idx + 3'd1;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= CW'(GAP_CYCLES - 1);
              state   <= GAP;
            end else if (byte_idx == 3'd3) begin
              out_busy <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - CW'(1);
          end else if (byte_idx == 3'd4) begin
            // byte_idx reaches 4 only after the last byte of the word went out
            out_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_transmitter.sv
// tb/tb_data_transmitter.sv - scoreboard bench for data_transmitter, GAP_CYCLES=2 and GAP_CYCLES=0
// instances driven by shared stimulus and checked against a timing/byte-order reference model.
module tb_data_transmitter;

  typedef struct packed {
    int         cyc;
    logic [7:0] b;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_data_ready = 1'b0;
  logic        in_tx_busy = 1'b0;

  logic [7:0]  o_data [2];
  logic        o_rdy  [2];
  logic        o_busy [2];
  logic        o_drop [2];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  ev_t        sq [2][$];
  ev_t        dq [2][$];
  ev_t        bq [2][$];
  logic [7:0] hold [2];

  bit          m_busy [2];
  int          m_left [2];
  int          m_next [2];
  int          m_done [2];
  logic [31:0] m_word [2];

  data_transmitter #(.GAP_CYCLES(2)) dut_gap2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_data_ready(in_data_ready),
    .in_tx_busy(in_tx_busy), .out_data(o_data[0]), .out_data_ready(o_rdy[0]),
    .out_busy(o_busy[0]), .out_dropped(o_drop[0])
  );

  data_transmitter #(.GAP_CYCLES(0)) dut_gap0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_data_ready(in_data_ready),
    .in_tx_busy(in_tx_busy), .out_data(o_data[1]), .out_data_ready(o_rdy[1]),
    .out_busy(o_busy[1]), .out_dropped(o_drop[1])
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic cmp(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got %0h want %0h", nm, i, edge_cnt, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_left[i] = 0;
      m_next[i] = 0;
      m_done[i] = 0;
      m_word[i] = '0;
      hold[i]   = 8'h00;
      sq[i].delete();
      dq[i].delete();
      bq[i].delete();
    end
  endtask

  // Reference: a word is four bytes MSB first; byte k+1 may leave no earlier than
  // GAP+1 edges after byte k and only when the link is free; busy drops GAP edges after the last byte.
  task automatic step(input logic dr, input logic [31:0] d, input logic b);
    int t;
    int g;
    @(negedge clk);
    in_data_ready = dr;
    in_data       = d;
    in_tx_busy    = b;
    t = edge_cnt + 1;
    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? 2 : 0;
      if (m_busy[i]) begin
        if (dr) dq[i].push_back('{cyc: t, b: 8'h00});
        if (m_left[i] > 0 && t >= m_next[i] && !b) begin
          sq[i].push_back('{cyc: t, b: m_word[i][31:24]});
          m_word[i] = m_word[i] << 8;
          m_left[i]--;
          m_next[i] = t + g + 1;
          if (m_left[i] == 0) m_done[i] = t + g;
        end
        if (m_left[i] == 0 && t >= m_done[i]) m_busy[i] = 1'b0;
      end else if (dr) begin
        m_busy[i] = 1'b1;
        m_word[i] = d;
        m_left[i] = 4;
        m_next[i] = t + 1;
      end
      bq[i].push_back('{cyc: t, b: {7'd0, m_busy[i]}});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom, 1'b0);
  endtask

  task automatic do_reset(input int hold_cycles);
    @(negedge clk);
    in_data_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp(i, "rst_data", o_data[i], 8'h00);
      cmp(i, "rst_strobe", o_rdy[i], 1'b0);
      cmp(i, "rst_busy", o_busy[i], 1'b0);
      cmp(i, "rst_drop", o_drop[i], 1'b0);
    end
    model_clear();
    repeat (hold_cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial forever begin
    logic es;
    logic ed;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      es = 1'b0;
      if (sq[i].size() > 0 && sq[i][0].cyc == edge_cnt) begin
        es = 1'b1;
        hold[i] = sq[i][0].b;
        void'(sq[i].pop_front());
      end
      cmp(i, "strobe", o_rdy[i], es);
      cmp(i, "byte", o_data[i], hold[i]);
      ed = 1'b0;
      if (dq[i].size() > 0 && dq[i][0].cyc == edge_cnt) begin
        ed = 1'b1;
        void'(dq[i].pop_front());
      end
      cmp(i, "dropped", o_drop[i], ed);
      if (bq[i].size() > 0 && bq[i][0].cyc == edge_cnt) begin
        cmp(i, "busy", o_busy[i], bq[i][0].b);
        void'(bq[i].pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp(i, "init_busy", o_busy[i], 1'b0);
      cmp(i, "init_strobe", o_rdy[i], 1'b0);
      cmp(i, "init_data", o_data[i], 8'h00);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: single word, link free
    step(1'b1, 32'h0A145836, 1'b0);
    idle(14);

    // 2: link busy for the first six edges after capture
    step(1'b1, 32'h0A145836, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1);
    idle(12);

    // 3 and 5: second request at capture+5 (dropped by GAP=2, accepted back-to-back by GAP=0)
    step(1'b1, 32'h0A145836, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b0);
    idle(14);

    step(1'b1, 32'hDEADBEEF, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'hCAFEF00D, 1'b0);
    idle(14);

    // 4: asynchronous reset between the 2nd and 3rd strobe of the GAP=2 instance
    step(1'b1, 32'h0A145836, 1'b0);
    repeat (5) step(1'b0, 32'h0, 1'b0);
    do_reset(2);
    idle(1);
    step(1'b1, 32'h01020304, 1'b0);
    idle(14);

    // 6: request held for three idle cycles
    repeat (3) step(1'b1, 32'h11223344, 1'b0);
    idle(14);

    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0);
    idle(20);

    for (int i = 0; i < 2; i++) cmp(i, "pending_strobes", sq[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
